// File: rtl/mac_pkg.sv
// Shared state encoding and arithmetic helpers for the MAC row engine.
package mac_pkg;

   typedef enum logic [2:0] {IDLE, RUN, DRAIN, POST, DONE} state_t;

   function automatic int beats_of(input int vec_len, input int lanes);
      return vec_len / lanes;
   endfunction

   // Clamp a wide signed value into the two's complement range of 'width' bits.
   function automatic logic signed [63:0] sat_signed(input logic signed [63:0] value,
                                                     input int width);
      logic signed [63:0] maxv;
      logic signed [63:0] minv;
      maxv = (64'sd1 <<< (width - 1)) - 64'sd1;
      minv = -(64'sd1 <<< (width - 1));
      if (value > maxv) return maxv;
      if (value < minv) return minv;
      return value;
   endfunction

endpackage

// File: rtl/flex_counter.sv
// Generic up-counter with synchronous clear; wraps to 1 after reaching rollover_val.
module flex_counter #(
   parameter int NUM_CNT_BITS = 4
) (
   input  logic                    clk,
   input  logic                    n_rst,
   input  logic                    clear,
   input  logic                    count_enable,
   input  logic [NUM_CNT_BITS-1:0] rollover_val,
   output logic [NUM_CNT_BITS-1:0] count_out,
   output logic                    rollover_flag
);

   logic [NUM_CNT_BITS-1:0] r_count;

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         r_count <= '0;
      end else if (clear) begin
         r_count <= '0;
      end else if (count_enable) begin
         r_count <= (r_count == rollover_val) ? NUM_CNT_BITS'(1)
                                              : r_count + NUM_CNT_BITS'(1);
      end
   end

   assign count_out     = r_count;
   assign rollover_flag = (r_count == rollover_val);

endmodule

// File: rtl/mac_lane_tree.sv
// Combinational LANES-way unsigned-pixel x signed-weight multiply and full-width sum.
module mac_lane_tree #(
   parameter int LANES = 2,
   parameter int PIX_W = 8,
   parameter int WGT_W = 16,
   parameter int SUM_W = 27
) (
   input  logic [LANES*PIX_W-1:0]  i_pix,
   input  logic [LANES*WGT_W-1:0]  i_wgt,
   output logic signed [SUM_W-1:0] o_sum
);

   localparam int PROD_W = PIX_W + WGT_W + 1;

   logic signed [PROD_W-1:0] w_prod [LANES];

   // Pixel is zero-extended so an unsigned 255 never reads as -1.
   for (genvar l = 0; l < LANES; l++) begin : g_lane
      logic signed [PROD_W-1:0] w_pix_ext;
      logic signed [PROD_W-1:0] w_wgt_ext;
      assign w_pix_ext = {{(WGT_W + 1){1'b0}}, i_pix[l*PIX_W +: PIX_W]};
      assign w_wgt_ext = {{(PIX_W + 1){i_wgt[l*WGT_W + WGT_W - 1]}}, i_wgt[l*WGT_W +: WGT_W]};
      assign w_prod[l] = w_pix_ext * w_wgt_ext;
   end

   always_comb begin
      o_sum = '0;
      for (int l = 0; l < LANES; l++) begin
         o_sum = o_sum + SUM_W'(w_prod[l]);
      end
   end

endmodule

// File: rtl/mac_row_engine.sv
// Dot-product engine for one fully-connected neuron row: stream, accumulate, bias, ReLU, saturate.
module mac_row_engine
   import mac_pkg::*;
#(
   parameter int LANES      = 2,
   parameter int VEC_LEN    = 784,
   parameter int NUM_ROWS   = 10,
   parameter int ROW_W      = 4,
   parameter int PIX_W      = 8,
   parameter int WGT_W      = 16,
   parameter int ACC_W      = 32,
   parameter int OUT_W      = 16,
   parameter int FRAC_SHIFT = 0,
   parameter int PIX_ADDR_W = 10,
   parameter int WGT_ADDR_W = 13,
   parameter int PIX_BASE   = 0,
   parameter int WGT_BASE   = 0
) (
   input  logic                          clk,
   input  logic                          n_rst,
   input  logic                          start,
   input  logic [ROW_W-1:0]              row_select,
   input  logic                          relu_en,
   input  logic signed [OUT_W-1:0]       bias_value,
   output logic [LANES*PIX_ADDR_W-1:0]   pix_addr,
   input  logic [LANES*PIX_W-1:0]        pix_data,
   output logic [LANES*WGT_ADDR_W-1:0]   wgt_addr,
   input  logic [LANES*WGT_W-1:0]        wgt_data,
   output logic                          busy,
   output logic                          done,
   output logic signed [OUT_W-1:0]       row_result,
   output logic                          overflow
);

   localparam int BEATS  = beats_of(VEC_LEN, LANES);
   localparam int CNT_W  = $clog2(BEATS + 1);
   localparam int PROD_W = PIX_W + WGT_W + 1;
   localparam int SUM_W  = PROD_W + $clog2(LANES) + 1;

   state_t                   r_state;
   logic                     r_busy;
   logic                     r_done;
   logic                     r_ovf;
   logic                     r_valid;
   logic                     r_relu;
   logic [ROW_W-1:0]         r_row;
   logic signed [OUT_W-1:0]  r_bias;
   logic signed [OUT_W-1:0]  r_result;
   logic signed [ACC_W-1:0]  r_acc;

   logic [CNT_W-1:0]         w_cnt;
   logic [CNT_W-1:0]         w_beat;
   logic                     w_rollover;
   logic                     w_cnt_en;
   logic                     w_accept;
   logic                     w_last_beat;
   logic signed [SUM_W-1:0]  w_lane_sum;
   logic signed [63:0]       w_acc_sum;
   logic signed [63:0]       w_acc_sat;
   logic signed [63:0]       w_v;
   logic signed [63:0]       w_v_relu;
   logic signed [63:0]       w_v_sat;
   logic                     w_acc_ovf;
   logic                     w_out_ovf;

   assign w_accept    = (r_state == IDLE) && start && (32'(row_select) < NUM_ROWS);
   assign w_last_beat = (w_cnt == CNT_W'(BEATS - 1));
   assign w_cnt_en    = (r_state == RUN) && !w_rollover;

   flex_counter #(
      .NUM_CNT_BITS(CNT_W)
   ) u_beat_cnt (
      .clk          (clk),
      .n_rst        (n_rst),
      .clear        (w_accept),
      .count_enable (w_cnt_en),
      .rollover_val (CNT_W'(BEATS)),
      .count_out    (w_cnt),
      .rollover_flag(w_rollover)
   );

   // Outside RUN every lane parks on its beat-0 address so the SRAMs never see X.
   always_comb begin
      w_beat   = (r_state == RUN) ? w_cnt : '0;
      pix_addr = '0;
      wgt_addr = '0;
      for (int l = 0; l < LANES; l++) begin
         pix_addr[l*PIX_ADDR_W +: PIX_ADDR_W] =
            PIX_ADDR_W'(PIX_BASE + 32'(w_beat) * LANES + l);
         wgt_addr[l*WGT_ADDR_W +: WGT_ADDR_W] =
            WGT_ADDR_W'(WGT_BASE + 32'(r_row) * VEC_LEN + 32'(w_beat) * LANES + l);
      end
   end

   mac_lane_tree #(
      .LANES(LANES),
      .PIX_W(PIX_W),
      .WGT_W(WGT_W),
      .SUM_W(SUM_W)
   ) u_tree (
      .i_pix(pix_data),
      .i_wgt(wgt_data),
      .o_sum(w_lane_sum)
   );

   // Saturating accumulate and post-processing are evaluated at 64 bits so nothing wraps.
   assign w_acc_sum = 64'(r_acc) + 64'(w_lane_sum);
   assign w_acc_sat = sat_signed(w_acc_sum, ACC_W);
   assign w_acc_ovf = (w_acc_sat != w_acc_sum);
   assign w_v       = (64'(r_acc) + (64'(r_bias) <<< FRAC_SHIFT)) >>> FRAC_SHIFT;
   assign w_v_relu  = (r_relu && (w_v < 64'sd0)) ? 64'sd0 : w_v;
   assign w_v_sat   = sat_signed(w_v_relu, OUT_W);
   assign w_out_ovf = (w_v_sat != w_v_relu);

   // Memory data lags the address by one cycle, so r_valid marks cycles carrying real data.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         r_state  <= IDLE;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
         r_ovf    <= 1'b0;
         r_valid  <= 1'b0;
         r_relu   <= 1'b0;
         r_row    <= '0;
         r_bias   <= '0;
         r_result <= '0;
         r_acc    <= '0;
      end else begin
         r_valid <= (r_state == RUN);
         r_done  <= 1'b0;
         case (r_state)
            IDLE: begin
               if (w_accept) begin
                  r_row   <= row_select;
                  r_relu  <= relu_en;
                  r_bias  <= bias_value;
                  r_acc   <= '0;
                  r_ovf   <= 1'b0;
                  r_busy  <= 1'b1;
                  r_state <= RUN;
               end
            end
            RUN: begin
               if (r_valid) begin
                  r_acc <= w_acc_sat[ACC_W-1:0];
                  if (w_acc_ovf) r_ovf <= 1'b1;
               end
               if (w_last_beat) r_state <= DRAIN;
            end
            DRAIN: begin
               if (r_valid) begin
                  r_acc <= w_acc_sat[ACC_W-1:0];
                  if (w_acc_ovf) r_ovf <= 1'b1;
               end
               r_state <= POST;
            end
            POST: begin
               r_result <= w_v_sat[OUT_W-1:0];
               if (w_out_ovf) r_ovf <= 1'b1;
               r_done  <= 1'b1;
               r_state <= DONE;
            end
            DONE: begin
               r_busy  <= 1'b0;
               r_state <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign busy       = r_busy;
   assign done       = r_done;
   assign row_result = r_result;
   assign overflow   = r_ovf;

endmodule

// File: doc/mac_row_engine.md
Name: mac_row_engine

Overview:
- Parametrised dot-product engine for one neuron row of a fully connected layer.
- Streams LANES pixel/weight pairs per cycle from synchronous-read memories and accumulates signed products over VEC_LEN inputs.
- Adds a per-row bias, applies an optional ReLU, then saturates the result to OUT_W.
- Sits between the layer controller (start/row_select/done) and the pixel and weight SRAMs; successor to the fixed 2-lane, 784-input row multiplier.

Parameters:
- LANES, 2, pixel/weight pairs fetched and multiplied per cycle; VEC_LEN % LANES == 0 required.
- VEC_LEN, 784, inputs per row.
- NUM_ROWS, 10, rows addressable by row_select.
- ROW_W, 4, row_select width.
- PIX_W, 8, pixel width, unsigned.
- WGT_W, 16, weight width, signed two's complement.
- ACC_W, 32, accumulator width, signed.
- OUT_W, 16, result and bias width, signed.
- FRAC_SHIFT, 0, arithmetic right shift applied after the bias add.
- PIX_ADDR_W, 10, pixel address width.
- WGT_ADDR_W, 13, weight address width.
- PIX_BASE, 0, pixel memory base address.
- WGT_BASE, 0, weight memory base address.

Ports:
- clk  in  1  clock
- n_rst  in  1  reset, asynchronous, active-low
- start  in  1  begin a row; sampled in IDLE only
- row_select  in  ROW_W  row index; latched on accepted start
- relu_en  in  1  ReLU enable; latched on accepted start
- bias_value  in  OUT_W  signed row bias; latched on accepted start
- pix_addr  out  LANES*PIX_ADDR_W  lane l at bits [l*PIX_ADDR_W +: PIX_ADDR_W]
- pix_data  in  LANES*PIX_W  read data, valid one cycle after address
- wgt_addr  out  LANES*WGT_ADDR_W  per-lane weight addresses
- wgt_data  in  LANES*WGT_W  read data, valid one cycle after address
- busy  out  1  high from the cycle after accepted start through the DONE cycle
- done  out  1  one-cycle pulse; row_result and overflow valid
- row_result  out  OUT_W  final signed result; held until the next accepted start
- overflow  out  1  saturation occurred in this row; held with row_result

Behaviour:
- Reset values: state IDLE; busy=0, done=0, row_result=0, overflow=0; accumulator 0; beat counter 0.
- BEATS = VEC_LEN/LANES.
- Start acceptance: start is accepted only in IDLE with row_select < NUM_ROWS. Otherwise it is ignored with no state change. start while busy is ignored.
- Accepted start does the following:
  - latches row_select, relu_en and bias_value;
  - clears the accumulator, beat counter and overflow;
  - sets next state to RUN.
- RUN, beat k = 0..BEATS-1, one beat per cycle:
  - pix_addr[l] = PIX_BASE + k*LANES + l
  - wgt_addr[l] = WGT_BASE + row*VEC_LEN + k*LANES + l
  - The data for beat k-1 is accumulated in the same cycle, gated by a registered valid bit.
  - After beat BEATS-1, go to DRAIN.
- Addresses outside RUN: each lane drives its beat-0 address, so no X values are produced.
- DRAIN (1 cycle): accumulate the final beat's data, then go to POST.
- POST (1 cycle), steps in order:
  - v = acc + sext(bias) << FRAC_SHIFT;
  - v >>>= FRAC_SHIFT;
  - if relu_en and v < 0, v = 0;
  - saturate v to the signed OUT_W range [-2^(OUT_W-1), 2^(OUT_W-1)-1];
  - register the result into row_result;
  - go to DONE.
- DONE (1 cycle): done=1, then return to IDLE.
- Latency: with start accepted at edge E0, done is high in the cycle after edge E0+BEATS+2. That is BEATS+3 cycles after start; 395 cycles for the defaults.
- Arithmetic:
  - Product = zero-extended pixel × signed weight, PIX_W+WGT_W+1 bits, signed.
  - Lane products are summed at full width, then added to the accumulator.
  - The accumulator saturates at the ACC_W signed bounds; it never wraps.
- overflow is sticky for the row. It is set by accumulator saturation or by output saturation. ReLU clamping alone does not set it.
- Simultaneous events: start in the DONE cycle is ignored; the controller re-issues it in IDLE.
- Reset mid-operation: everything returns immediately to reset values. The aborted row produces no done pulse.

Decomposition:
- mac_pkg holds:
  - state enum {IDLE, RUN, DRAIN, POST, DONE};
  - function sat_signed(value, width);
  - localparam BEATS derivation helper.
- Beat counter: reuse the existing flex_counter with NUM_CNT_BITS=$clog2(BEATS+1), rollover_val=BEATS, clear on accepted start.
- One new sub-module, mac_lane_tree: combinational LANES-way multiply and sum, generate loop, full-width signed output.

Test Plan:
- All pixels 1, all weights 1, row 0, bias 0, relu off -> row_result=784, overflow=0, done exactly 395 cycles after start, single pulse.
- Pixels 255, weights 0xFFFF (-1), relu off -> sum -199920, row_result=-32768 (0x8000), overflow=1. Same with relu on -> row_result=0, overflow=0.
- row_select=3 -> first beat wgt_addr={2352,2353}, pix_addr={0,1}; last beat wgt_addr={3134,3135}, pix_addr={782,783}.
- Pixels 0, bias=-5 -> relu off gives -5; relu on gives 0. Bias latched at start: bias changed mid-run has no effect.
- start pulsed during RUN and start with row_select=10 in IDLE -> both ignored; busy and result unaffected.
- n_rst asserted at beat 100 -> busy/done/row_result/overflow=0 immediately, no done pulse. Fresh start then completes correctly.
